// File: rtl/sr_frame_ctrl.sv
// Parallel-to-serial frame controller driving an external DW-bit right-shift register datapath.
// Latency: word accepted at T appears on ser_out at T+1..T+DW; GAP idle cycles follow each frame.
// Backpressure: in_ready low while shifting (except last bit when GAP=0), during GAP and CLR.
// Optional SR_FRAME_MSB_FIRST_EN: load bit-reversed word so the frame is sent MSB first.
module sr_frame_ctrl #(
    parameter int   DW   = 4,
    parameter int   GAP  = 1,
    parameter logic FILL = 1'b0
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          abort,
    output logic          sr_sync_rst,
    output logic          sr_load,
    output logic          sr_en,
    output logic [DW-1:0] sr_data,
    output logic          sr_data_h,
    input  logic [DW-1:0] sr_q,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          frame_start,
    output logic          frame_end,
    output logic          busy
);

    localparam int BW = $clog2(DW + 1);
    localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_CLR,
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          last_bit;

    // Only bit 0 of the datapath is observed; upper bits are intentionally ignored.
    logic unused_q_hi;
    assign unused_q_hi = ^sr_q[DW-1:1];

    assign last_bit  = (bcnt == BIT_LAST);
    assign sr_data_h = FILL;
    assign ser_out   = sr_q[0];
    assign busy      = (state != S_IDLE) || sr_sync_rst;

`ifdef SR_FRAME_MSB_FIRST_EN
    // Reverse the word so the LSB-first shifter emits the original MSB first.
    always_comb begin
        sr_data = '0;
        for (int i = 0; i < DW; i++) begin
            sr_data[i] = in_data[DW-1-i];
        end
    end
`else
    assign sr_data = in_data;
`endif

    // State, counters and datapath clear request.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state       <= S_CLR;
            bcnt        <= '0;
            gcnt        <= '0;
            sr_sync_rst <= 1'b1;
        end else begin
            state       <= state_n;
            bcnt        <= bcnt_n;
            gcnt        <= gcnt_n;
            sr_sync_rst <= (state_n == S_CLR);
        end
    end

    // Next-state and datapath control; abort overrides everything outside CLR.
    always_comb begin
        state_n     = state;
        bcnt_n      = bcnt;
        gcnt_n      = gcnt;
        in_ready    = 1'b0;
        sr_load     = 1'b0;
        sr_en       = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_CLR: begin
                state_n = S_IDLE;
            end
            S_IDLE: begin
                if (abort) begin
                    state_n = S_CLR;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        sr_load = 1'b1;
                        state_n = S_SHIFT;
                        bcnt_n  = '0;
                    end
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_n = S_CLR;
                end else begin
                    ser_valid   = 1'b1;
                    frame_start = (bcnt == '0);
                    frame_end   = last_bit;
                    if (!last_bit) begin
                        sr_en  = 1'b1;
                        bcnt_n = bcnt + BW'(1);
                    end else if (GAP > 0) begin
                        sr_en   = 1'b1;
                        state_n = S_GAP;
                        bcnt_n  = '0;
                        gcnt_n  = '0;
                    end else begin
                        // Last bit is already on ser_out, so a new word may replace the final shift.
                        in_ready = 1'b1;
                        bcnt_n   = '0;
                        if (in_valid) begin
                            sr_load = 1'b1;
                        end else begin
                            sr_en   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_CLR;
                end else begin
                    gcnt_n = gcnt + GW'(1);
                    if (gcnt == GAP_LAST) begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_CLR;
            end
        endcase
    end

endmodule

// File: doc/sr_frame_ctrl.md
# sr_frame_ctrl

Frame controller that sequences the team's DW-bit right-shift register datapath (sync_rst/load/en/data/data_h/q port set) as a parallel-to-serial transmitter. Accepts words over a valid/ready handshake, issues one load followed by DW shift enables, and qualifies the resulting serial bit stream with valid and frame markers. It also enforces an inter-frame gap and supports abort.

## Interface
- DW, 4: word width; must match the controlled shift register (≥2)
- GAP, 1: idle cycles inserted after each frame (0 allowed)
- FILL, 1'b0: value driven on sr_data_h (shift-in bit)

- clk  in  1  clock, rising edge
- async_rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  word offered
- in_data  in  DW  word to transmit
- in_ready  out  1  controller can accept a word this cycle
- abort  in  1  terminate current frame and clear datapath
- sr_sync_rst  out  1  to datapath sync_rst
- sr_load  out  1  to datapath load
- sr_en  out  1  to datapath en
- sr_data  out  DW  to datapath data
- sr_data_h  out  1  to datapath data_h, constant FILL
- sr_q  in  DW  from datapath q
- ser_out  out  1  serial bit, = sr_q[0]
- ser_valid  out  1  ser_out carries a frame bit
- frame_start  out  1  first bit of frame
- frame_end  out  1  last bit of frame
- busy  out  1  state ≠ IDLE or sr_sync_rst=1

## Operation
- States: CLR, IDLE, SHIFT, GAP. Registered: state, bit counter bcnt (clog2(DW+1) bits), gap counter gcnt (clog2(GAP+1) bits, min 1), sr_sync_rst.
- Reset: state=CLR, bcnt=0, gcnt=0, sr_sync_rst=1. All other outputs 0 during reset (in_ready=0, sr_load=0, sr_en=0, ser_valid=0).
- CLR: sr_sync_rst=1, in_ready=0; next IDLE, sr_sync_rst→0.
- IDLE: in_ready=1. Accept = in_valid & in_ready & ~abort → sr_load=1, sr_data=in_data (combinational same cycle); next SHIFT, bcnt=0.
- SHIFT: ser_valid=1, sr_en=1, bcnt increments; frame_start when bcnt=0; frame_end when bcnt=DW-1. At bcnt=DW-1: GAP>0 → GAP, gcnt=0; GAP=0 → IDLE.
- GAP: in_ready=0, gcnt increments; at gcnt=GAP-1 → IDLE.
- Back-to-back (GAP=0 only): in_ready=1 also in SHIFT at bcnt=DW-1; accept there drives sr_load=1, sr_en=0 (load instead of final shift; bit 0 already presented), next SHIFT, bcnt=0.
- Abort (any state except CLR): sr_load, sr_en, ser_valid, frame_start, frame_end, in_ready forced 0 that cycle; next state CLR. Abort beats a concurrent in_valid (word not accepted).
- sr_load and sr_en never both 1. sr_data_h=FILL always; sr_data=in_data when not loading (don't-care).

## Timing
- Accept at cycle T → bits on ser_out at T+1..T+DW, LSB first; frame_start at T+1, frame_end at T+DW.
- in_ready returns high at T+DW+GAP+1 (GAP>0) or T+DW (GAP=0).
- Throughput: DW+GAP+1 cycles/word (GAP>0), DW cycles/word (GAP=0).
- Reset release: CLR for first edge, in_ready=1 from second cycle after release.
- Abort at cycle A → sr_sync_rst=1 at A+1, in_ready=1 at A+2.

## Configuration
- SR_FRAME_MSB_FIRST_EN defined: sr_data = bit-reversed in_data (sr_data[i]=in_data[DW-1-i]), so ser_out emits in_data MSB first; all timing unchanged.
- Undefined: sr_data=in_data, LSB first.

## Test plan
- DW=4, GAP=1, word 4'b1011 after reset → ser_out 1,1,0,1 at T+1..T+4, frame_start at T+1, frame_end at T+4, in_ready low T+1..T+5, high T+6.
- DW=4, GAP=0, in_valid held with 4'hA then 4'h5 → 8 contiguous ser_valid cycles, bits 0,1,0,1,1,0,1,0; sr_load at T and T+4, sr_en never with sr_load.
- Abort at bcnt=2 of 4'hF with in_valid=1 → ser_valid 0 that cycle, sr_sync_rst=1 next cycle, no word accepted, in_ready=1 two cycles after abort.
- async_rst asserted mid-SHIFT → outputs immediately 0, sr_sync_rst=1; after release one CLR cycle then IDLE.
- SR_FRAME_MSB_FIRST_EN, DW=4, word 4'b1000 → ser_out 1,0,0,0.
- in_valid low for 20 cycles in IDLE → no sr_load/sr_en, ser_valid 0, busy 0.
